// File: rtl/seq_detector_pkg.sv
// Shared definitions for the symbol-sequence detector: mode encodings
// and the helper that folds raw configuration codes onto them.
package seq_detector_pkg;

  localparam int MODE_W = 2;

  // Detection modes. The unused code 3 is folded onto MODE_OVL when loaded.
  typedef enum logic [MODE_W-1:0] {
    MODE_OVL  = 2'd0,
    MODE_NOVL = 2'd1,
    MODE_RUN  = 2'd2
  } det_mode_t;

  // Map a raw 2-bit mode code onto a legal mode. Code 3 becomes MODE_OVL.
  function automatic det_mode_t to_mode(input logic [MODE_W-1:0] code);
    det_mode_t m;
    case (code)
      2'd1:    m = MODE_NOVL;
      2'd2:    m = MODE_RUN;
      default: m = MODE_OVL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Symbol stream, configuration and result signals of the sequence detector.
// The master drives the stream and configuration; the slave is the detector.
interface seq_detector_if #(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8
);

  logic                     in_valid;
  logic [SYM_W-1:0]         sym;
  logic                     cfg_we;
  logic [PAT_LEN*SYM_W-1:0] cfg_pattern;
  logic [1:0]               cfg_mode;
  logic                     cnt_clr;
  logic                     match;
  logic                     match_pulse;
  logic [CNT_W-1:0]         match_cnt;

  modport master (
    output in_valid, sym, cfg_we, cfg_pattern, cfg_mode, cnt_clr,
    input  match, match_pulse, match_cnt
  );

  modport slave (
    input  in_valid, sym, cfg_we, cfg_pattern, cfg_mode, cnt_clr,
    output match, match_pulse, match_cnt
  );

endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear has priority; increment stops once the counter reaches all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Symbol-sequence detector. Keeps the last PAT_LEN accepted symbols (oldest
// in slice 0, newest in the top slice) and a fill count, and flags a hit when
// a full history equals the programmed pattern. Hits drive a level output,
// a one-cycle strobe and a saturating occurrence counter.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int                           SYM_W       = 2,
  parameter int                           PAT_LEN     = 3,
  parameter int                           CNT_W       = 8,
  parameter logic [PAT_LEN*SYM_W-1:0]     DEF_PATTERN = 6'b11_10_01,
  parameter logic [1:0]                   DEF_MODE    = 2'd2
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_detector_if.slave bus
);

  localparam int HIST_W = PAT_LEN * SYM_W;
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [HIST_W-1:0] pattern_q, pattern_d;
  det_mode_t         mode_q, mode_d;
  logic              match_q, match_d;
  logic              pulse_q, pulse_d;

  logic [SYM_W-1:0]  last_sym;
  logic [HIST_W-1:0] hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              suppress;
  logic              accept;
  logic              hit;

  // Acceptance, candidate history and hit detection for the current symbol.
  always_comb begin
    last_sym   = hist_q[HIST_W-1 -: SYM_W];
    hist_shift = {bus.sym, hist_q[HIST_W-1:SYM_W]};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    // In run-tolerant mode a repeat of the newest symbol is a run, not a new symbol.
    suppress   = (mode_q == MODE_RUN) && (fill_q != '0) && (bus.sym == last_sym);
    accept     = bus.in_valid && !bus.cfg_we && !suppress;
    hit        = accept && (fill_inc == FILL_FULL) && (hist_shift == pattern_q);
  end

  // Next-state selection: configuration load, accepted symbol, or hold.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    mode_d    = mode_q;
    match_d   = match_q;
    pulse_d   = 1'b0;
    if (bus.cfg_we) begin
      // History is left alone; a zero fill already forces a full refill.
      pattern_d = bus.cfg_pattern;
      mode_d    = to_mode(bus.cfg_mode);
      fill_d    = '0;
      match_d   = 1'b0;
    end else if (accept) begin
      hist_d  = hist_shift;
      // Non-overlapping mode restarts the fill so the next occurrence shares nothing.
      fill_d  = (hit && (mode_q == MODE_NOVL)) ? '0 : fill_inc;
      match_d = hit;
      pulse_d = hit;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      mode_q    <= to_mode(DEF_MODE);
      match_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      match_q   <= match_d;
      pulse_q   <= pulse_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .cnt   (bus.match_cnt)
  );

  assign bus.match       = match_q;
  assign bus.match_pulse = pulse_q;

endmodule
